wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 Parameter DWIDTH, default 32: data path width in bits.
REQ-002 Parameter AWIDTH, default 32: instruction address width in bits.
REQ-003 Port clk, input, 1: single clock; all state updates on rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous, active-high.
REQ-005 Port memtoregin, input, 2: writeback source select from MEM/WB register.
REQ-006 Port regwrin, input, 1: writeback enable from MEM/WB register.
REQ-007 Port regdstmuxin, input, 5: destination register index.
REQ-008 Port aluoutin, input, DWIDTH: ALU result.
REQ-009 Port dmdatain, input, DWIDTH: data memory read data.
REQ-010 Port pcnextin, input, AWIDTH: PC+4 of the retiring instruction, used as the link value.
REQ-011 Port negativein, input, 1: ALU negative flag, used for set-less-than.
REQ-012 Port rsaddr, input, 5: read port A index.
REQ-013 Port rtaddr, input, 5: read port B index.
REQ-014 Port rsdata, output, DWIDTH: read port A data.
REQ-015 Port rtdata, output, DWIDTH: read port B data.
REQ-016 Port wbdata, output, DWIDTH: selected writeback value, combinational, for EX forwarding.
REQ-017 Port wbaddr, output, 5: equals regdstmuxin.
REQ-018 Port wbvalid, output, 1: high when an effective write occurs this cycle.
REQ-019 Port wrcount, output, 32: count of effective writes since reset.

Function
REQ-020 Writeback select, per memtoregin: 00 -> aluoutin; 01 -> dmdatain; 10 -> pcnextin; 11 -> negativein.
REQ-021 Select 10: pcnextin is zero-extended to DWIDTH when AWIDTH < DWIDTH and truncated to DWIDTH when AWIDTH > DWIDTH.
REQ-022 Select 11: wbdata is {DWIDTH-1 zeros, negativein}.
REQ-023 Effective write: regwrin=1 AND regdstmuxin!=0 AND rst=0; wbvalid is asserted under exactly this condition.
REQ-024 On each rising clk edge with an effective write, register[regdstmuxin] takes wbdata; latency from input to storage is one edge.
REQ-025 Register 0 always reads 0; writes to index 0 are discarded and do not assert wbvalid.
REQ-026 Read ports are combinational: data = register[addr].
REQ-027 Write-through bypass: when an effective write targets addr in the current cycle, the read port returns wbdata instead of the stored value.
REQ-028 Both read ports bypass independently; rsaddr=rtaddr returns identical data on both ports.
REQ-029 wrcount increments by 1 on each rising edge with an effective write and saturates at 0xFFFFFFFF; it does not wrap.
REQ-030 Inputs hold no state in this block; every cycle presents a new retiring instruction (no stall input).

Reset
REQ-031 rst=1 asynchronously clears registers 1..31 and wrcount to 0, independent of clk.
REQ-032 While rst=1: no write occurs, wbvalid=0, and rsdata/rtdata read 0 (no bypass).
REQ-033 A write whose edge coincides with rst assertion is lost; the first write is accepted on the first rising edge after rst deasserts.

Structure
REQ-034 Shared package holds: MEMTOREG_ALU=2'b00, MEMTOREG_MEM=2'b01, MEMTOREG_LINK=2'b10, MEMTOREG_SLT=2'b11, NUM_REGS=32, REG_AW=5, and the DWIDTH/AWIDTH defaults.
REQ-035 The writeback selection (REQ-020..022) is a separate combinational sub-module, wb_mux, instantiated once.
REQ-036 Storage is a 31-entry register array; index 0 is not stored.

Verification
REQ-037 Reset clears: write 0xDEADBEEF to r5, assert rst mid-cycle -> rsaddr=5 reads 0 immediately, and wrcount=0.
REQ-038 Source select: write r1 with each memtoregin: 00 (alu=0x11), 01 (dm=0x22), 10 (pc=0x00400004), 11 (neg=1) -> r1 reads 0x11, 0x22, 0x00400004, 0x00000001 on successive cycles.
REQ-039 Zero register: regwrin=1, dst=0, alu=0xFFFFFFFF -> rsaddr=0 reads 0, wbvalid=0, wrcount unchanged.
REQ-040 Bypass: r7 holds 0x5; in the same cycle write r7=0x9 with rsaddr=rtaddr=7 -> both ports read 0x9 before the edge and after it.
REQ-041 regwrin=0, dst=3, alu=0x77 -> r3 keeps its prior value, wbvalid=0.
REQ-042 Counter saturation: force wrcount to 0xFFFFFFFE, perform 3 effective writes -> wrcount reads 0xFFFFFFFF, 0xFFFFFFFF, 0xFFFFFFFF.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
// Shared constants for the writeback stage and register file.
package wb_regfile_pkg;

  localparam int DEF_DWIDTH = 32;
  localparam int DEF_AWIDTH = 32;
  localparam int NUM_REGS   = 32;
  localparam int REG_AW     = 5;

  typedef logic [1:0] memtoreg_t;

  localparam memtoreg_t MEMTOREG_ALU  = 2'b00;
  localparam memtoreg_t MEMTOREG_MEM  = 2'b01;
  localparam memtoreg_t MEMTOREG_LINK = 2'b10;
  localparam memtoreg_t MEMTOREG_SLT  = 2'b11;

endpackage

// File: rtl/wb_regfile_wb_mux.sv
// Writeback source selection: ALU result, memory data, link address or SLT flag.
module wb_mux
  import wb_regfile_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH
) (
  input  logic [1:0]        memtoregin,
  input  logic [DWIDTH-1:0] aluoutin,
  input  logic [DWIDTH-1:0] dmdatain,
  input  logic [AWIDTH-1:0] pcnextin,
  input  logic              negativein,
  output logic [DWIDTH-1:0] wbdata
);

  logic [DWIDTH-1:0] link_val;

  // The link address is resized to the data path: truncated if wider, zero-padded if narrower.
  generate
    if (AWIDTH >= DWIDTH) begin : g_link_trunc
      assign link_val = pcnextin[DWIDTH-1:0];
    end else begin : g_link_ext
      assign link_val = {{(DWIDTH-AWIDTH){1'b0}}, pcnextin};
    end
  endgenerate

  // Pick the writeback value for the retiring instruction.
  always_comb begin
    wbdata = '0;
    case (memtoregin)
      MEMTOREG_ALU:  wbdata = aluoutin;
      MEMTOREG_MEM:  wbdata = dmdatain;
      MEMTOREG_LINK: wbdata = link_val;
      MEMTOREG_SLT:  wbdata = {{(DWIDTH-1){1'b0}}, negativein};
      default:       wbdata = '0;
    endcase
  end

endmodule

// File: rtl/wb_regfile.sv
// 32-entry register file with writeback mux, write-through read bypass and a
// saturating count of effective writes. r0 is hardwired to zero and not stored.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int DWIDTH = DEF_DWIDTH,
  parameter int AWIDTH = DEF_AWIDTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        memtoregin,
  input  logic              regwrin,
  input  logic [4:0]        regdstmuxin,
  input  logic [DWIDTH-1:0] aluoutin,
  input  logic [DWIDTH-1:0] dmdatain,
  input  logic [AWIDTH-1:0] pcnextin,
  input  logic              negativein,
  input  logic [4:0]        rsaddr,
  input  logic [4:0]        rtaddr,
  output logic [DWIDTH-1:0] rsdata,
  output logic [DWIDTH-1:0] rtdata,
  output logic [DWIDTH-1:0] wbdata,
  output logic [4:0]        wbaddr,
  output logic              wbvalid,
  output logic [31:0]       wrcount
);

  // Entry k of the array holds architectural register k+1.
  logic [DWIDTH-1:0] regs_q [0:NUM_REGS-2];
  logic [31:0]       wrcount_q;
  logic [31:0]       wrcount_d;
  logic              wr_en;
  logic [REG_AW-1:0] wr_idx;

  wb_mux #(
    .DWIDTH(DWIDTH),
    .AWIDTH(AWIDTH)
  ) u_wb_mux (
    .memtoregin(memtoregin),
    .aluoutin  (aluoutin),
    .dmdatain  (dmdatain),
    .pcnextin  (pcnextin),
    .negativein(negativein),
    .wbdata    (wbdata)
  );

  assign wr_en   = regwrin && (regdstmuxin != '0) && !rst;
  assign wr_idx  = regdstmuxin - 5'd1;
  assign wbaddr  = regdstmuxin;
  assign wbvalid = wr_en;
  assign wrcount = wrcount_q;

  // Register storage: cleared by reset, written with the selected value on an effective write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS - 1; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_en) begin
      regs_q[wr_idx] <= wbdata;
    end
  end

  // Write counter sticks at all-ones instead of wrapping.
  always_comb begin
    wrcount_d = wrcount_q;
    if (wr_en && (wrcount_q != 32'hFFFF_FFFF)) begin
      wrcount_d = wrcount_q + 32'd1;
    end
  end

  // Write counter state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrcount_q <= '0;
    end else begin
      wrcount_q <= wrcount_d;
    end
  end

  // Two identical read ports; each forwards the in-flight write when addresses match.
  logic [REG_AW-1:0] rd_addr [2];
  logic [DWIDTH-1:0] rd_data [2];

  assign rd_addr[0] = rsaddr;
  assign rd_addr[1] = rtaddr;
  assign rsdata     = rd_data[0];
  assign rtdata     = rd_data[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      logic [REG_AW-1:0] rd_idx;
      assign rd_idx = rd_addr[gi] - 5'd1;

      // Read port: zero in reset or for r0, bypass on a matching write, else stored value.
      always_comb begin
        rd_data[gi] = '0;
        if (rst || (rd_addr[gi] == '0)) begin
          rd_data[gi] = '0;
        end else if (wr_en && (rd_addr[gi] == regdstmuxin)) begin
          rd_data[gi] = wbdata;
        end else begin
          rd_data[gi] = regs_q[rd_idx];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: stimulus queues expected values tagged with the
// cycle they belong to; a monitor compares them against the DUT on the falling edge.
module tb_wb_regfile;

  typedef enum int {SIG_RS, SIG_RT, SIG_WB, SIG_VALID, SIG_CNT} sig_e;

  typedef struct {
    int          cyc;
    sig_e        sig;
    logic [31:0] exp;
    string       name;
  } item_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  memtoregin = 2'b00;
  logic        regwrin = 1'b0;
  logic [4:0]  regdstmuxin = 5'd0;
  logic [31:0] aluoutin = 32'h0;
  logic [31:0] dmdatain = 32'h0;
  logic [31:0] pcnextin = 32'h0;
  logic        negativein = 1'b0;
  logic [4:0]  rsaddr = 5'd0;
  logic [4:0]  rtaddr = 5'd0;
  logic [31:0] rsdata, rtdata, wbdata, wrcount;
  logic [4:0]  wbaddr;
  logic        wbvalid;

  item_t exp_q[$];
  int    cyc = 0;
  int    checks = 0;
  int    passes = 0;

  wb_regfile dut (
    .clk        (clk),
    .rst        (rst),
    .memtoregin (memtoregin),
    .regwrin    (regwrin),
    .regdstmuxin(regdstmuxin),
    .aluoutin   (aluoutin),
    .dmdatain   (dmdatain),
    .pcnextin   (pcnextin),
    .negativein (negativein),
    .rsaddr     (rsaddr),
    .rtaddr     (rtaddr),
    .rsdata     (rsdata),
    .rtdata     (rtdata),
    .wbdata     (wbdata),
    .wbaddr     (wbaddr),
    .wbvalid    (wbvalid),
    .wrcount    (wrcount)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: on every falling edge, compare everything expected for this cycle.
  initial begin
    logic [31:0] act;
    item_t it;
    forever begin
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        it = exp_q.pop_front();
        checks++;
        if (it.cyc < cyc) begin
          $display("FAIL %s: not sampled in its cycle (tag %0d, now %0d)", it.name, it.cyc, cyc);
        end else begin
          case (it.sig)
            SIG_RS:    act = rsdata;
            SIG_RT:    act = rtdata;
            SIG_WB:    act = wbdata;
            SIG_VALID: act = {31'd0, wbvalid};
            default:   act = wrcount;
          endcase
          if (act === it.exp) begin
            passes++;
            $display("cyc %0d %s: got 0x%08h ok", cyc, it.name, act);
          end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", it.name, act, it.exp);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_sig(input sig_e s, input logic [31:0] e, input string n);
    item_t it;
    it.cyc  = cyc;
    it.sig  = s;
    it.exp  = e;
    it.name = n;
    exp_q.push_back(it);
  endtask

  task automatic drive(input logic we, input logic [4:0] dst, input logic [1:0] sel,
                       input logic [31:0] alu, input logic [4:0] ra, input logic [4:0] rb);
    regwrin     = we;
    regdstmuxin = dst;
    memtoregin  = sel;
    aluoutin    = alu;
    rsaddr      = ra;
    rtaddr      = rb;
  endtask

  initial begin
    dmdatain   = 32'h22;
    pcnextin   = 32'h0040_0004;
    negativein = 1'b1;

    // Held in reset: a write attempt is ignored, reads are zero.
    step();
    drive(1'b1, 5'd5, 2'b00, 32'h1234, 5'd5, 5'd5);
    expect_sig(SIG_VALID, 32'd0, "rst_wbvalid");
    expect_sig(SIG_RS,    32'd0, "rst_rs_no_bypass");
    expect_sig(SIG_CNT,   32'd0, "rst_wrcount");

    step();
    rst = 1'b0;
    drive(1'b0, 5'd0, 2'b00, 32'h0, 5'd5, 5'd0);
    expect_sig(SIG_RS, 32'd0, "post_rst_r5");

    // Each source select into r1, then read back from storage.
    step();
    drive(1'b1, 5'd1, 2'b00, 32'h11, 5'd0, 5'd0);
    expect_sig(SIG_WB,    32'h11, "sel_alu_wbdata");
    expect_sig(SIG_VALID, 32'd1,  "sel_alu_wbvalid");
    step();
    drive(1'b1, 5'd1, 2'b01, 32'hAA, 5'd2, 5'd1);
    expect_sig(SIG_WB, 32'h22, "sel_mem_wbdata");
    expect_sig(SIG_RT, 32'h22, "sel_mem_bypass");
    step();
    drive(1'b0, 5'd1, 2'b00, 32'hAA, 5'd1, 5'd0);
    expect_sig(SIG_RS, 32'h22, "r1_mem_stored");
    step();
    drive(1'b1, 5'd1, 2'b10, 32'hAA, 5'd0, 5'd0);
    expect_sig(SIG_WB, 32'h0040_0004, "sel_link_wbdata");
    step();
    drive(1'b0, 5'd1, 2'b00, 32'hAA, 5'd1, 5'd0);
    expect_sig(SIG_RS, 32'h0040_0004, "r1_link_stored");
    step();
    drive(1'b1, 5'd1, 2'b11, 32'hAA, 5'd0, 5'd0);
    expect_sig(SIG_WB, 32'h1, "sel_slt_wbdata");
    step();
    drive(1'b0, 5'd1, 2'b11, 32'hAA, 5'd1, 5'd0);
    expect_sig(SIG_RS,  32'h1, "r1_slt_stored");
    expect_sig(SIG_CNT, 32'd4, "wrcount_after_4");
    negativein = 1'b0;
    expect_sig(SIG_WB,  32'h0, "sel_slt_neg0");

    // Write to r0 is discarded.
    step();
    drive(1'b1, 5'd0, 2'b00, 32'hFFFF_FFFF, 5'd0, 5'd0);
    expect_sig(SIG_RS,    32'd0, "r0_reads_zero");
    expect_sig(SIG_VALID, 32'd0, "r0_wbvalid");
    step();
    drive(1'b0, 5'd0, 2'b00, 32'h0, 5'd0, 5'd0);
    expect_sig(SIG_CNT, 32'd4, "r0_wrcount_held");

    // Bypass on both ports.
    drive(1'b1, 5'd7, 2'b00, 32'h5, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd7, 2'b00, 32'h9, 5'd7, 5'd7);
    expect_sig(SIG_RS, 32'h5, "r7_prior");
    step();
    drive(1'b1, 5'd7, 2'b00, 32'h9, 5'd7, 5'd7);
    expect_sig(SIG_RS, 32'h9, "bypass_rs");
    expect_sig(SIG_RT, 32'h9, "bypass_rt");
    step();
    drive(1'b0, 5'd7, 2'b00, 32'h0, 5'd7, 5'd7);
    expect_sig(SIG_RS, 32'h9, "r7_stored_rs");
    expect_sig(SIG_RT, 32'h9, "r7_stored_rt");

    // Disabled write to r3, plus independent bypass on port B only.
    step();
    drive(1'b1, 5'd3, 2'b00, 32'h33, 5'd7, 5'd3);
    expect_sig(SIG_RS, 32'h9,  "indep_rs_stored");
    expect_sig(SIG_RT, 32'h33, "indep_rt_bypass");
    step();
    drive(1'b0, 5'd3, 2'b00, 32'h77, 5'd3, 5'd0);
    expect_sig(SIG_RS,    32'h33, "r3_nowrite_same");
    expect_sig(SIG_VALID, 32'd0,  "r3_nowrite_valid");
    step();
    expect_sig(SIG_RS, 32'h33, "r3_nowrite_after");

    // Asynchronous reset mid-cycle clears stored data and the counter.
    step();
    drive(1'b1, 5'd5, 2'b00, 32'hDEAD_BEEF, 5'd0, 5'd0);
    step();
    drive(1'b0, 5'd5, 2'b00, 32'h0, 5'd5, 5'd7);
    expect_sig(SIG_RS, 32'hDEAD_BEEF, "r5_before_rst");
    step();
    #2;
    rst = 1'b1;
    #1;
    expect_sig(SIG_RS,  32'd0, "r5_async_clear");
    expect_sig(SIG_RT,  32'd0, "r7_async_clear");
    expect_sig(SIG_CNT, 32'd0, "wrcount_async_clear");
    step();
    rst = 1'b0;
    drive(1'b0, 5'd0, 2'b00, 32'h0, 5'd5, 5'd0);
    expect_sig(SIG_RS, 32'd0, "r5_stays_clear");

    // Saturation of the write counter.
    step();
    force dut.wrcount_q = 32'hFFFF_FFFE;
    #1;
    release dut.wrcount_q;
    drive(1'b1, 5'd2, 2'b00, 32'h1, 5'd0, 5'd0);
    expect_sig(SIG_CNT, 32'hFFFF_FFFE, "cnt_preset");
    step();
    expect_sig(SIG_CNT, 32'hFFFF_FFFF, "cnt_sat_1");
    step();
    expect_sig(SIG_CNT, 32'hFFFF_FFFF, "cnt_sat_2");
    step();
    drive(1'b0, 5'd0, 2'b00, 32'h0, 5'd0, 5'd0);
    expect_sig(SIG_CNT, 32'hFFFF_FFFF, "cnt_sat_3");

    step();
    step();
    while (exp_q.size() > 0) begin
      item_t it;
      it = exp_q.pop_front();
      checks++;
      $display("FAIL %s: never checked, expected 0x%08h", it.name, it.exp);
    end
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  // Watchdog so the run cannot hang.
  initial begin
    #50000;
    $display("FAIL watchdog: timeout at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
